// File: rtl/servant_loader_pkg.sv
// servant_loader_pkg: shared state encoding and byte-select helpers for the Wishbone loader
package servant_loader_pkg;
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, CHECK, DONE} state_t;
  function automatic logic [3:0] sel_mask(input logic [2:0] k);
    return 4'((5'd1 << k) - 5'd1);
  endfunction
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction
endpackage

// File: rtl/servant_loader_pack.sv
// servant_loader_pack: little-endian byte-to-word packer; word/sel/cnt include a byte taken this cycle
module servant_loader_pack
  import servant_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        take,
  input  logic [7:0]  dat,
  output logic [31:0] word,
  output logic [3:0]  sel,
  output logic [2:0]  cnt
);
  logic [3:0][7:0] lanes;
  logic [3:0][7:0] raw;
  logic [1:0] idx;
  always_comb begin
    raw = lanes;
    if (take) raw[idx] = dat;
  end
  assign cnt = {1'b0, idx} + {2'b0, take};
  assign sel = sel_mask(cnt);
  assign word = raw & lane_mask(sel);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lanes <= '0;
      idx <= '0;
    end else if (clr) begin
      lanes <= '0;
      idx <= '0;
    end else if (take) begin
      lanes[idx] <= dat;
      idx <= idx + 2'd1;
    end
endmodule

// File: rtl/servant_wb_loader.sv
// servant_wb_loader: streams bytes into a Wishbone RAM as words, optionally reading each word back
module servant_wb_loader
  import servant_loader_pkg::*;
#(
  parameter int depth = 256,
  parameter int aw = $clog2(depth),
  parameter bit VERIFY = 1
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst,
  input  logic          i_start,
  input  logic [7:0]    i_dat,
  input  logic          i_vld,
  output logic          o_rdy,
  input  logic          i_flush,
  output logic [aw-1:2] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  input  logic [31:0]   i_wb_rdt,
  input  logic          i_wb_ack,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [aw-2:0] o_count
);
  localparam logic [aw-1:2] last_adr = (aw-2)'(depth/4 - 1);
  state_t state;
  logic fin;
  logic [3:0] msk;
  logic [31:0] pk_word;
  logic [3:0] pk_sel;
  logic [2:0] pk_cnt;
  logic take, clr, idle;
  assign idle = state == IDLE || state == DONE;
  assign take = i_vld & o_rdy;
  assign clr = (state == COLLECT && i_flush) || (idle && i_start);
  servant_loader_pack u_pack (
    .clk(i_wb_clk),
    .rst(i_wb_rst),
    .clr(clr),
    .take(take),
    .dat(i_dat),
    .word(pk_word),
    .sel(pk_sel),
    .cnt(pk_cnt)
  );
  always_ff @(posedge i_wb_clk or posedge i_wb_rst)
    if (i_wb_rst) begin
      state <= IDLE;
      o_wb_cyc <= 1'b0;
      o_wb_we <= 1'b0;
      o_wb_sel <= '0;
      o_wb_adr <= '0;
      o_wb_dat <= '0;
      o_rdy <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_err <= 1'b0;
      o_count <= '0;
      fin <= 1'b0;
      msk <= '0;
    end else begin
      case (state)
        IDLE, DONE:
          if (i_start) begin
            state <= COLLECT;
            o_wb_adr <= '0;
            o_count <= '0;
            o_err <= 1'b0;
            o_done <= 1'b0;
            o_busy <= 1'b1;
            o_rdy <= 1'b1;
          end
        COLLECT:
          if (pk_cnt[2] || (i_flush && pk_cnt != 3'd0)) begin
            state <= WRITE;
            o_rdy <= 1'b0;
            o_wb_cyc <= 1'b1;
            o_wb_we <= 1'b1;
            o_wb_dat <= pk_word;
            o_wb_sel <= pk_sel;
            msk <= pk_sel;
            fin <= i_flush || o_wb_adr == last_adr;
          end else if (i_flush) begin
            state <= DONE;
            o_rdy <= 1'b0;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end
        WRITE:
          if (i_wb_ack) begin
            o_wb_cyc <= 1'b0;
            o_wb_we <= 1'b0;
            o_count <= o_count + (aw-1)'(1);
            if (VERIFY) state <= CHECK;
            else begin
              state <= fin ? DONE : COLLECT;
              o_wb_adr <= fin ? o_wb_adr : o_wb_adr + (aw-2)'(1);
              o_rdy <= !fin;
              o_busy <= !fin;
              o_done <= fin;
            end
          end
        CHECK:
          // first CHECK cycle keeps cyc low so the read is a separate bus cycle
          if (!o_wb_cyc) begin
            o_wb_cyc <= 1'b1;
            o_wb_sel <= 4'hF;
          end else if (i_wb_ack) begin
            o_wb_cyc <= 1'b0;
            if (|((i_wb_rdt ^ o_wb_dat) & lane_mask(msk))) o_err <= 1'b1;
            state <= fin ? DONE : COLLECT;
            o_wb_adr <= fin ? o_wb_adr : o_wb_adr + (aw-2)'(1);
            o_rdy <= !fin;
            o_busy <= !fin;
            o_done <= fin;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_servant_wb_loader.sv
// tb_servant_wb_loader: random byte streams against a RAM responder; expected bus traffic derived from the byte list
module tb_servant_wb_loader;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, vld = 1'b0, flush = 1'b0, ack = 1'b0;
  logic [7:0] dat = 8'h0;
  logic rdy, we, cyc, busy, done, err;
  logic [5:0] adr;
  logic [31:0] wdat, rdt = 32'h0;
  logic [3:0] sel;
  logic [6:0] count;
  int checks = 0, errors = 0;
  int flip_word = -1;
  logic [31:0] mem [64];
  typedef struct {logic we; logic [5:0] adr; logic [31:0] dat; logic [3:0] sel;} txn_t;
  txn_t log_q[$];
  byte unsigned sent[$];

  always #5 clk = ~clk;

  servant_wb_loader #(.depth(256), .aw(8), .VERIFY(1)) dut (
    .i_wb_clk(clk), .i_wb_rst(rst), .i_start(start), .i_dat(dat), .i_vld(vld),
    .o_rdy(rdy), .i_flush(flush), .o_wb_adr(adr), .o_wb_dat(wdat), .o_wb_sel(sel),
    .o_wb_we(we), .o_wb_cyc(cyc), .i_wb_rdt(rdt), .i_wb_ack(ack), .o_busy(busy),
    .o_done(done), .o_err(err), .o_count(count)
  );

  function automatic logic [31:0] bmask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // RAM responder: ack one cycle after cyc, held for one cycle
  always @(posedge clk or posedge rst)
    if (rst) ack <= 1'b0;
    else if (cyc && !ack) begin
      ack <= 1'b1;
      rdt <= mem[adr] ^ ((flip_word == int'(adr)) ? 32'h20 : 32'h0);
      if (we) mem[adr] <= (mem[adr] & ~bmask(sel)) | (wdat & bmask(sel));
      log_q.push_back('{we, adr, wdat, sel});
    end else ack <= 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(input string tag);
    int t = 0;
    while (!rdy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(tag, t < 200, 1);
  endtask

  task automatic begin_load();
    log_q.delete();
    sent.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic put(input byte unsigned b, input logic fl, input int gap);
    vld = 1'b1;
    dat = b;
    flush = fl;
    wait_rdy("put_timeout");
    @(negedge clk);
    vld = 1'b0;
    flush = 1'b0;
    sent.push_back(b);
    repeat (gap) @(negedge clk);
  endtask

  task automatic flush0();
    flush = 1'b1;
    wait_rdy("flush_timeout");
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", t < 2000, 1);
  endtask

  // expected traffic: word w = bytes 4w..4w+3 little-endian, partial tail gets low-k sel; each write followed by a read
  task automatic check_load();
    int n = sent.size();
    int nw = (n + 3) / 4;
    chk("bus_cycles", log_q.size(), 2 * nw);
    for (int w = 0; w < nw; w++) begin
      int k = (n - 4 * w > 4) ? 4 : n - 4 * w;
      logic [31:0] e = 32'h0;
      logic [3:0] es = 4'((1 << k) - 1);
      for (int i = 0; i < k; i++) e = e | (32'(sent[4 * w + i]) << (8 * i));
      if (2 * w + 1 < log_q.size()) begin
        chk("wr_we", log_q[2 * w].we, 1);
        chk("wr_adr", log_q[2 * w].adr, w);
        chk("wr_dat", log_q[2 * w].dat, e);
        chk("wr_sel", log_q[2 * w].sel, es);
        chk("rd_we", log_q[2 * w + 1].we, 0);
        chk("rd_adr", log_q[2 * w + 1].adr, w);
        chk("rd_sel", log_q[2 * w + 1].sel, 4'hF);
      end
    end
    chk("count", count, nw);
    chk("done", done, 1);
    chk("busy", busy, 0);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_cyc", cyc, 0);
    chk("rst_rdy", rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    rst = 1'b0;
    @(negedge clk);

    // single word, then a flush with nothing pending
    begin_load();
    chk("start_busy", busy, 1);
    put(8'h13, 0, 0);
    put(8'h04, 0, 1);
    put(8'h00, 0, 0);
    put(8'h00, 0, 2);
    wait_rdy("word0_back");
    chk("w0_cycles", log_q.size(), 2);
    chk("w0_dat", log_q[0].dat, 32'h00000413);
    chk("w0_sel", log_q[0].sel, 4'hF);
    chk("w0_err", err, 0);
    chk("w0_count", count, 1);
    flush0();
    wait_done();
    check_load();

    // six bytes then a separate flush
    begin_load();
    for (int i = 0; i < 6; i++) put(8'($urandom), 0, $urandom_range(0, 2));
    flush0();
    wait_done();
    check_load();
    chk("six_err", err, 0);

    // random lengths; flush either with the last byte or on its own
    for (int tr = 0; tr < 8; tr++) begin
      int n = (tr == 0) ? 8 : (tr == 1) ? 7 : $urandom_range(1, 13);
      logic with_last = (tr < 2) ? 1'b1 : 1'($urandom);
      begin_load();
      for (int i = 0; i < n; i++)
        put(8'($urandom), (i == n - 1) && with_last, $urandom_range(0, 1));
      if (!with_last) flush0();
      wait_done();
      check_load();
      chk("rand_err", err, 0);
    end

    // corrupted read-back on word 2 sets a sticky error
    flip_word = 2;
    begin_load();
    for (int i = 0; i < 16; i++) put(8'($urandom), 0, 0);
    chk("flip_err_mid", err, 1);
    flush0();
    wait_done();
    check_load();
    chk("flip_err_end", err, 1);
    flip_word = -1;
    begin_load();
    chk("restart_err", err, 0);
    chk("restart_done", done, 0);
    flush0();
    wait_done();
    check_load();

    // fill the whole RAM; extra bytes refused
    begin_load();
    for (int i = 0; i < 256; i++) put(8'($urandom), 0, 0);
    wait_done();
    check_load();
    chk("full_last_adr", log_q[log_q.size() - 1].adr, 63);
    vld = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("refuse_rdy", rdy, 0);
    end
    vld = 1'b0;
    chk("full_count", count, 64);

    // asynchronous reset in the middle of a write cycle
    begin_load();
    for (int i = 0; i < 4; i++) put(8'($urandom), 0, 0);
    wait_rdy("rst_word0");
    for (int i = 0; i < 4; i++) begin
      vld = (i < 3) ? 1'b1 : vld;
      put(8'($urandom), 0, 0);
    end
    begin
      int t = 0;
      while (!cyc && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk("rst_wait_cyc", t < 50, 1);
    end
    chk("pre_rst_adr", adr, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_cyc", cyc, 0);
    chk("arst_we", we, 0);
    chk("arst_sel", sel, 0);
    chk("arst_adr", adr, 0);
    chk("arst_dat", wdat, 0);
    chk("arst_rdy", rdy, 0);
    chk("arst_busy", busy, 0);
    chk("arst_count", count, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_cyc", cyc, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    chk("post_rst_count", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
